oven_key_conditioner: RTL and testbench
=======================================

OVEN_KEY_CONDITIONER -- requirements
Module: oven_key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 1000000: the number of consecutive stable cycles needed to accept a key change (20 ms at 50 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY_CYC, default 25000000: the hold time before auto-repeat starts (0.5 s).
REQ-003 SHALL have parameter REPEAT_RATE_CYC, default 5000000: the auto-repeat period (0.1 s).
REQ-004 SHALL have parameters TEMP_MIN, TEMP_MAX, TEMP_STEP and TEMP_INIT, defaults 150, 500, 5 and 350: setpoint lower clamp, upper clamp, step size and reset value, in degrees.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port key_n, input, 4 bits: raw active-low push buttons. [0] = power, [1] = up, [2] = down, [3] = start.
REQ-008 SHALL have port key_pressed, output, 4 bits: the debounced level of each key; 1 = pressed.
REQ-009 SHALL have port power_on, output, 1 bit: the oven-enable level.
REQ-010 SHALL have port start_pulse, output, 1 bit: a one-cycle bake-start request.
REQ-011 SHALL have port setpoint, output, 10 bits: the target temperature in degrees, unsigned.
REQ-012 SHALL have port setpoint_changed, output, 1 bit: a one-cycle strobe when setpoint takes a new value.

Function
REQ-013 SHALL pass each key_n bit through a 2-flop synchronizer; synchronizer flops preset to 1 (released).
REQ-014 SHALL give each key its own debounce counter; key_pressed[i] toggles only after the synchronized input differs from it for DEBOUNCE_CYC consecutive cycles.
REQ-015 SHALL clear a key's debounce counter whenever its synchronized input equals key_pressed[i] again, so a glitch shorter than DEBOUNCE_CYC produces no change.
REQ-016 SHALL generate a press event when key_pressed[i] goes 0->1; release events are ignored; latency from raw edge to key_pressed is 2 + DEBOUNCE_CYC cycles.
REQ-017 SHALL toggle power_on on each power press event.
REQ-018 SHALL assert start_pulse for exactly one cycle, in the cycle after a start press event, only if power_on=1 at that event; otherwise the event is dropped.
REQ-019 SHALL, on an up step, set setpoint to min(setpoint+TEMP_STEP, TEMP_MAX); on a down step, set it to max(setpoint-TEMP_STEP, TEMP_MIN); intermediate arithmetic is at least 11 bits so nothing wraps.
REQ-020 SHALL pulse setpoint_changed for one cycle, coincident with the setpoint update, only when the value actually changes; no pulse when already at a clamp.
REQ-021 SHALL adjust setpoint regardless of power_on; a power toggle never alters setpoint.
REQ-022 SHALL run a repeat FSM with states IDLE, DELAY and REPEAT, plus one shared 25-bit cycle counter.
REQ-023 SHALL, in IDLE, on an up or down press event (not both): apply one step, load the counter and go to DELAY.
REQ-024 SHALL, in DELAY, after REPEAT_DELAY_CYC cycles with the same key still pressed: apply one step and go to REPEAT.
REQ-025 SHALL, in REPEAT, apply one step every REPEAT_RATE_CYC cycles while the key remains pressed.
REQ-026 SHALL return from DELAY or REPEAT to IDLE in the cycle the active key's key_pressed falls, or when the opposite key becomes pressed; no step is applied on that cycle.
REQ-027 SHALL ignore up and down press events that occur in the same cycle: no step, FSM stays IDLE.
REQ-028 SHALL process power, start and up/down events in the same cycle independently.

Reset
REQ-029 SHALL, with rst high at a clock edge, set: setpoint=TEMP_INIT, power_on=0, start_pulse=0, setpoint_changed=0, key_pressed=0, all counters 0, FSM=IDLE, synchronizers=1.
REQ-030 SHALL treat a key held through reset as a fresh press: it reports after 2 + DEBOUNCE_CYC cycles and generates a press event.

Verification
(Run with DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=5.)
REQ-031 SHALL cover power press then start press -> power_on=1, then exactly one start_pulse; a start press with power_on=0 -> no start_pulse.
REQ-032 SHALL cover a 3-cycle low glitch on key_n[1] -> key_pressed unchanged, setpoint stays 350, no setpoint_changed.
REQ-033 SHALL cover holding up for 60 cycles from reset -> setpoint 355, then 360 about 20 cycles later, then +5 every 5 cycles; stops on release.
REQ-034 SHALL cover a held down from 160 -> 155, 150, then stays at 150 with no further setpoint_changed.
REQ-035 SHALL cover up and down released and pressed in the same cycle -> no step; rst asserted mid-REPEAT at 420 -> setpoint 350, power_on 0, FSM IDLE.

Source files
------------

// File: rtl/oven_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : oven_key_conditioner
// Brief   : Debounces four oven keys and derives power, start and setpoint
//           control with auto-repeat on the up/down keys.
// Revision: 1.0 - initial release
// ============================================================================
module oven_key_conditioner #(
  parameter int DEBOUNCE_CYC     = 1000000,
  parameter int REPEAT_DELAY_CYC = 25000000,
  parameter int REPEAT_RATE_CYC  = 5000000,
  parameter int TEMP_MIN         = 150,
  parameter int TEMP_MAX         = 500,
  parameter int TEMP_STEP        = 5,
  parameter int TEMP_INIT        = 350
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  output logic [3:0] key_pressed,
  output logic       power_on,
  output logic       start_pulse,
  output logic [9:0] setpoint,
  output logic       setpoint_changed
);

  localparam int              c_DB_W       = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC);
  localparam logic [c_DB_W-1:0] c_DB_LAST  = c_DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [24:0]     c_DELAY_LAST = 25'(REPEAT_DELAY_CYC - 1);
  localparam logic [24:0]     c_RATE_LAST  = 25'(REPEAT_RATE_CYC - 1);
  localparam logic [10:0]     c_MIN        = 11'(TEMP_MIN);
  localparam logic [10:0]     c_MAX        = 11'(TEMP_MAX);
  localparam logic [10:0]     c_STEP       = 11'(TEMP_STEP);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  logic [3:0]  r_sync1, r_sync2;
  logic [3:0]  w_raw, w_key, r_key_d, w_press;
  logic        r_power, r_start, r_changed;
  logic [9:0]  r_sp;
  state_t      r_state, w_state_nxt;
  logic        r_dir, w_dir_nxt;
  logic [24:0] r_rcnt, w_rcnt_nxt;
  logic        w_step, w_act, w_opp;
  logic [10:0] w_sp_ext, w_sp_up, w_sp_dn, w_sp_new;

  // Synchronizers preset to released so a held key looks like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw = ~r_sync2;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      logic [c_DB_W-1:0] r_cnt;
      logic              r_lvl;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
          r_lvl <= 1'b0;
        end else if (w_raw[gi] != r_lvl) begin
          if (r_cnt == c_DB_LAST) begin
            r_lvl <= w_raw[gi];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end
      assign w_key[gi] = r_lvl;
    end
  endgenerate

  assign w_press = w_key & ~r_key_d;

  // Direction of the key being repeated: 0 = up, 1 = down.
  assign w_act = r_dir ? w_key[2] : w_key[1];
  assign w_opp = r_dir ? w_key[1] : w_key[2];

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_rcnt_nxt  = r_rcnt;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press[1] ^ w_press[2]) begin
          w_step      = 1'b1;
          w_dir_nxt   = w_press[2];
          w_rcnt_nxt  = '0;
          w_state_nxt = S_DELAY;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (!w_act || w_opp) begin
          w_rcnt_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else if (r_rcnt == ((r_state == S_DELAY) ? c_DELAY_LAST : c_RATE_LAST)) begin
          w_step      = 1'b1;
          w_rcnt_nxt  = '0;
          w_state_nxt = S_REPEAT;
        end else begin
          w_rcnt_nxt  = r_rcnt + 25'd1;
        end
      end
      default: begin
        w_rcnt_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // 11-bit working width keeps the clamp comparisons free of wrap-around.
  assign w_sp_ext = {1'b0, r_sp};
  assign w_sp_up  = ((w_sp_ext + c_STEP) > c_MAX) ? c_MAX : (w_sp_ext + c_STEP);
  assign w_sp_dn  = (w_sp_ext < (c_MIN + c_STEP)) ? c_MIN : (w_sp_ext - c_STEP);
  assign w_sp_new = w_dir_nxt ? w_sp_dn : w_sp_up;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_d   <= 4'h0;
      r_power   <= 1'b0;
      r_start   <= 1'b0;
      r_state   <= S_IDLE;
      r_dir     <= 1'b0;
      r_rcnt    <= '0;
      r_sp      <= 10'(TEMP_INIT);
      r_changed <= 1'b0;
    end else begin
      r_key_d   <= w_key;
      r_power   <= r_power ^ w_press[0];
      r_start   <= w_press[3] & r_power;
      r_state   <= w_state_nxt;
      r_dir     <= w_dir_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_changed <= w_step && (w_sp_new != w_sp_ext);
      if (w_step) begin
        r_sp <= w_sp_new[9:0];
      end
    end
  end

  assign key_pressed      = w_key;
  assign power_on         = r_power;
  assign start_pulse      = r_start;
  assign setpoint         = r_sp;
  assign setpoint_changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_oven_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_oven_key_conditioner
// Brief   : Directed vector table plus multi-cycle sequences for the key
//           conditioner, with short debounce/repeat timing.
// Revision: 1.0 - initial release
// ============================================================================
module tb_oven_key_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic [3:0] key_pressed;
  logic       power_on, start_pulse, setpoint_changed;
  logic [9:0] setpoint;

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;
  int n_chg = 0;

  always #5 clk = ~clk;

  oven_key_conditioner #(
    .DEBOUNCE_CYC    (4),
    .REPEAT_DELAY_CYC(20),
    .REPEAT_RATE_CYC (5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .key_n           (key_n),
    .key_pressed     (key_pressed),
    .power_on        (power_on),
    .start_pulse     (start_pulse),
    .setpoint        (setpoint),
    .setpoint_changed(setpoint_changed)
  );

  always @(negedge clk) begin
    if (start_pulse)      n_start++;
    if (setpoint_changed) n_chg++;
  end

  typedef struct {
    logic [3:0] kn;
    int         cyc;
    logic [3:0] kp;
    logic       pwr;
    logic [9:0] sp;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after n rising edges.
  task automatic step_n(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    key_n = 4'hF;
    step_n(2);
    rst   = 1'b0;
  endtask

  // Hold one adjust key from reset; model steps at edge 6, edge 26 and every
  // 5 edges after, until the debounced release lands at edge hold+5.
  task automatic hold_check(input logic [3:0] kn, input bit down,
                            input int hold, input int total, input string tag);
    int exp_sp;
    int nxt;
    bit exp_chg;
    exp_sp = 350;
    key_n  = kn;
    for (int k = 0; k < total; k++) begin
      if (k == hold) key_n = 4'hF;
      step_n(1);
      exp_chg = 1'b0;
      if (k == 6 || (k >= 26 && (k - 26) % 5 == 0 && k <= hold + 5)) begin
        nxt = down ? ((exp_sp - 5 < 150) ? 150 : exp_sp - 5)
                   : ((exp_sp + 5 > 500) ? 500 : exp_sp + 5);
        exp_chg = (nxt != exp_sp);
        exp_sp  = nxt;
      end
      check($sformatf("%s_sp_e%0d", tag, k), int'(setpoint), exp_sp);
      check($sformatf("%s_chg_e%0d", tag, k), int'(setpoint_changed), int'(exp_chg));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    //            key_n   cyc  kp       pwr   sp
    tbl[0]  = '{4'b1111, 2, 4'b0000, 1'b0, 10'd350};
    tbl[1]  = '{4'b1110, 5, 4'b0000, 1'b0, 10'd350};
    tbl[2]  = '{4'b1110, 1, 4'b0001, 1'b0, 10'd350};
    tbl[3]  = '{4'b1110, 1, 4'b0001, 1'b1, 10'd350};
    tbl[4]  = '{4'b1111, 8, 4'b0000, 1'b1, 10'd350};
    tbl[5]  = '{4'b1101, 7, 4'b0010, 1'b1, 10'd355};
    tbl[6]  = '{4'b1111, 8, 4'b0000, 1'b1, 10'd355};
    tbl[7]  = '{4'b1011, 7, 4'b0100, 1'b1, 10'd350};
    tbl[8]  = '{4'b1111, 8, 4'b0000, 1'b1, 10'd350};
    tbl[9]  = '{4'b1110, 7, 4'b0001, 1'b0, 10'd350};
    tbl[10] = '{4'b1111, 8, 4'b0000, 1'b0, 10'd350};

    @(negedge clk);
    do_reset();
    check("rst_kp",  int'(key_pressed), 0);
    check("rst_pwr", int'(power_on), 0);
    check("rst_sp",  int'(setpoint), 350);
    check("rst_st",  int'(start_pulse), 0);
    check("rst_chg", int'(setpoint_changed), 0);

    for (int i = 0; i < 11; i++) begin
      key_n = tbl[i].kn;
      step_n(tbl[i].cyc);
      check($sformatf("vec%0d_kp", i),  int'(key_pressed), int'(tbl[i].kp));
      check($sformatf("vec%0d_pwr", i), int'(power_on),    int'(tbl[i].pwr));
      check($sformatf("vec%0d_sp", i),  int'(setpoint),    int'(tbl[i].sp));
    end

    // Start with power off is dropped; with power on gives one pulse.
    do_reset();
    n_start = 0;
    key_n = 4'b0111; step_n(10);
    key_n = 4'b1111; step_n(10);
    check("start_off_cnt", n_start, 0);
    key_n = 4'b1110; step_n(10);
    key_n = 4'b1111; step_n(10);
    check("start_pwr", int'(power_on), 1);
    key_n = 4'b0111; step_n(10);
    key_n = 4'b1111; step_n(10);
    check("start_on_cnt", n_start, 1);

    // Three-cycle glitch on the up key.
    do_reset();
    c0 = n_chg;
    key_n = 4'b1101; step_n(3);
    key_n = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      step_n(1);
      check($sformatf("glitch_kp%0d", k), int'(key_pressed), 0);
    end
    check("glitch_sp",  int'(setpoint), 350);
    check("glitch_chg", n_chg - c0, 0);

    do_reset();
    hold_check(4'b1101, 1'b0, 60, 100, "up");
    do_reset();
    hold_check(4'b1011, 1'b1, 260, 280, "dn");

    // Up and down together: no step.
    do_reset();
    c0 = n_chg;
    key_n = 4'b1001; step_n(30);
    check("both_kp", int'(key_pressed), 6);
    key_n = 4'b1111; step_n(10);
    check("both_sp",  int'(setpoint), 350);
    check("both_chg", n_chg - c0, 0);

    // Reset in the middle of auto-repeat with power on.
    do_reset();
    key_n = 4'b1100; step_n(87);
    check("mid_sp",  int'(setpoint), 420);
    check("mid_pwr", int'(power_on), 1);
    rst = 1'b1; step_n(1);
    check("mid_rst_sp",  int'(setpoint), 350);
    check("mid_rst_pwr", int'(power_on), 0);
    check("mid_rst_kp",  int'(key_pressed), 0);
    check("mid_rst_chg", int'(setpoint_changed), 0);
    rst = 1'b0; step_n(6);
    check("held_kp",  int'(key_pressed), 3);
    check("held_sp0", int'(setpoint), 350);
    step_n(1);
    check("held_sp1", int'(setpoint), 355);
    check("held_chg", int'(setpoint_changed), 1);
    check("held_pwr", int'(power_on), 1);
    key_n = 4'hF; step_n(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
